// File: rtl/stream_mux.sv
// Registered N-channel stream multiplexer with manual or round-robin selection
// and a single valid/ready output stage.
module stream_mux #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // state | meaning
  // EMPTY | output register holds no word, out_valid = 0
  // FULL  | output register holds a word awaiting out_ready
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic               load_en;
  logic               grant_vld;
  logic [SEL_W-1:0]   grant_idx;
  logic [SEL_W-1:0]   ptr_next;
  logic [SEL_W:0]     cand;

  assign out_valid = (state == FULL);
  assign load_en   = (state == EMPTY) || out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!mode) begin
      if (({1'b0, sel} < N_EXT) && in_valid[sel]) begin
        grant_vld = 1'b1;
        grant_idx = sel;
      end
    end else begin
      // Wrap is done by subtraction so non-power-of-two channel counts work.
      for (int k = 0; k < CHANNELS; k++) begin
        cand = {1'b0, ptr} + (SEL_W+1)'(k);
        if (cand >= N_EXT) cand = cand - N_EXT;
        if (!grant_vld && in_valid[cand[SEL_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[SEL_W-1:0];
        end
      end
    end
  end

  assign ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;

  assign in_ready = (rst_n && load_en && grant_vld) ? (CHANNELS'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_ch   <= '0;
      ptr      <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        state    <= FULL;
        out_data <= in_data[grant_idx*WIDTH +: WIDTH];
        out_ch   <= grant_idx;
        if (mode) ptr <= ptr_next;
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised, registered N-channel stream multiplexer, the clocked successor to the team's 8:1 combinational bit mux. It selects one of `CHANNELS` input streams of `WIDTH` bits and presents it through a single output register with a valid/ready handshake. Selection is either external (manual select) or by an internal round-robin arbiter over valid channels. It sits between parallel producers and a single shared consumer, such as a shared bus or a serialiser.

## Interface
- `WIDTH`, default 8, data width per channel (≥1).
- `CHANNELS`, default 8, number of input channels (≥2).
- `SEL_W`, derived as `$clog2(CHANNELS)`; a localparam, not overridable.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mode`  in  1  0 = manual select, 1 = round-robin.
- `sel`  in  SEL_W  manual channel index; used only when `mode`=0.
- `in_data`  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  CHANNELS  per-channel valid.
- `in_ready`  out  CHANNELS  per-channel ready, one-hot or zero.
- `out_data`  out  WIDTH  registered output data.
- `out_ch`  out  SEL_W  index of the channel that supplied `out_data`.
- `out_valid`  out  1  output holds a word.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- Output stage has two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `load_en` = !`out_valid` | `out_ready`. Throughput is one word per cycle under continuous `out_ready`.
- Grant is computed combinationally each cycle:
  - Manual mode: grant = `sel` if `sel` < CHANNELS and `in_valid[sel]`=1; otherwise no grant. Other channels are never granted, even if valid.
  - Round-robin mode: grant = first i with `in_valid[i]`=1, searching from `ptr` upward and wrapping modulo CHANNELS; no grant if all `in_valid`=0.
- `in_ready[g]` = `load_en` & grant valid & (g == grant). All other `in_ready` bits are 0.
- A transfer on channel g occurs when `in_valid[g]` & `in_ready[g]` are both 1. On a transfer: `out_data` ← channel g data, `out_ch` ← g, `out_valid` ← 1.
- If `load_en`=1 and there is no grant: `out_valid` ← 0. `out_data` and `out_ch` hold their last values.
- If `out_valid`=1 and `out_ready`=0: `out_data`, `out_ch` and `out_valid` hold, and all `in_ready` bits are 0.
- `ptr` (SEL_W bits, internal):
  - On a transfer in round-robin mode, `ptr` ← (g+1) mod CHANNELS. This wraps from CHANNELS-1 to 0, and must be correct for non-power-of-two CHANNELS.
  - `ptr` does not change in manual mode.
  - `ptr` is not cleared on a change of `mode`.
- A `mode` or `sel` change takes effect in the same cycle's grant. A word already in the output register is unaffected.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on `out_data`/`out_valid` after edge k.
- Simultaneous consume and load: when `out_valid`=1, `out_ready`=1 and a grant exists, the old word is consumed and the new word loads on the same edge, so `out_valid` stays 1 with no bubble.
- `in_ready` is combinational from `out_valid`, `out_ready`, `mode`, `sel`, `in_valid` and `ptr`. It has no dependency on `in_data`.
- Reset, applied on any edge while `rst_n`=0, including mid-stream with `out_valid`=1: `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0. While `rst_n`=0, `in_ready` is forced to 0. Any pending word is dropped.
- After the first edge with `rst_n`=1, behaviour is normal. The first grant in round-robin mode searches from channel 0.

## Test plan
- Manual pass-through (W=8, N=8): `mode`=0, `sel`=5, `in_valid`=8'hFF, ch5=8'hA5, `out_ready`=1 → `in_ready`=8'b0010_0000; next cycle `out_data`=8'hA5, `out_ch`=5, `out_valid`=1.
- Back-pressure: FULL with 8'h3C, `out_ready`=0 for 4 cycles while ch5 changes to 8'h11 → `out_data` holds 8'h3C and `in_ready`=0 for all 4 cycles; with `out_ready`=1, 8'h11 loads on the next edge.
- Round-robin fairness: `mode`=1, all valid, `out_ready`=1 for 10 cycles → `out_ch` sequence is 0,1,2,…,7,0,1; `ptr` wraps from 7 to 0.
- Round-robin skip: `in_valid`=8'b1000_0100, `ptr`=3 → grants 7, then 2, then 7; channels with `in_valid`=0 are never granted.
- Manual miss: `sel`=4 with `in_valid[4]`=0 and others valid → no grant, `in_ready`=0; after the current word is consumed, `out_valid` drops to 0 and `out_data` holds.
- Reset mid-stream: `rst_n`=0 for one edge while FULL with 8'hEE and `ptr`=6 → `out_valid`=0, `out_data`=0, `out_ch`=0; the next round-robin grant with all valid is channel 0. Repeat the fairness check with N=5, W=12: `out_ch` is 0..4,0.
